// File: rtl/riscv_fetch_queue.sv
// Instruction-fetch front end: credit-limited pipelined icache requests feeding a
// DEPTH-entry PC-tagged prefetch queue, with redirect flush and stale-response discard.
module riscv_fetch_queue #(
   parameter int          DEPTH        = 4,
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        icache_addr_valid,
   output logic [31:0] icache_addr,
   input  logic        icache_addr_ready,
   input  logic        icache_data_ready,
   input  logic [31:0] icache_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        instr_ready
);

   localparam int          CW      = $clog2(DEPTH + 1);
   localparam int          PW      = $clog2(DEPTH);
   localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

   logic [31:0]   fetch_pc;
   logic [31:0]   resp_pc;
   logic [CW-1:0] count;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] drop_cnt;
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [31:0]   mem_instr [DEPTH];
   logic [31:0]   mem_pc    [DEPTH];

   logic [31:0]   target_pc;
   logic [CW:0]   credit_used;
   logic          accept;
   logic          enq;
   logic          deq;
   logic          queue_empty;
   logic          unused_target_bits;

   assign target_pc          = {redirect_target[31:2], 2'b00};
   assign unused_target_bits = ^redirect_target[1:0];

   // Buffered words are about to be flushed in a redirect cycle, so only in-flight ones hold credit.
   assign credit_used = (redirect_valid ? {(CW + 1){1'b0}} : {1'b0, count}) + {1'b0, outstanding};

   assign icache_addr_valid = rst_n & (credit_used < DEPTH_C);
   assign icache_addr       = redirect_valid ? target_pc : fetch_pc;
   assign accept            = icache_addr_valid & icache_addr_ready;

   assign queue_empty = (count == '0);
   assign instr_valid = ~queue_empty & ~redirect_valid;
   assign instr       = queue_empty ? 32'h0000_0013 : mem_instr[head];
   assign instr_pc    = queue_empty ? resp_pc : mem_pc[head];

   assign enq = icache_data_ready & ~redirect_valid & (drop_cnt == '0);
   assign deq = instr_valid & instr_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc    <= RESET_VECTOR;
         resp_pc     <= RESET_VECTOR;
         count       <= '0;
         outstanding <= '0;
         drop_cnt    <= '0;
         head        <= '0;
         tail        <= '0;
      end else begin
         if (accept) begin
            fetch_pc <= icache_addr + 32'd4;
         end else if (redirect_valid) begin
            fetch_pc <= target_pc;
         end

         outstanding <= outstanding + CW'(accept) - CW'(icache_data_ready);

         if (redirect_valid) begin
            // Everything in flight before this cycle belongs to the old path.
            count    <= '0;
            head     <= '0;
            tail     <= '0;
            resp_pc  <= target_pc;
            drop_cnt <= outstanding - CW'(icache_data_ready);
         end else begin
            if (icache_data_ready && (drop_cnt != '0)) begin
               drop_cnt <= drop_cnt - CW'(1);
            end
            if (enq) begin
               tail    <= tail + PW'(1);
               resp_pc <= resp_pc + 32'd4;
            end
            if (deq) begin
               head <= head + PW'(1);
            end
            count <= count + CW'(enq) - CW'(deq);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         mem_instr[tail] <= icache_data;
         mem_pc[tail]    <= resp_pc;
      end
   end

endmodule

// File: tb/tb_riscv_fetch_queue.sv
// Directed bench for riscv_fetch_queue: an in-order fixed-latency icache model plus
// per-scenario tasks comparing delivered PCs/words against hand-computed expectations.
module tb_riscv_fetch_queue;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        icache_addr_valid;
   logic [31:0] icache_addr;
   logic        icache_addr_ready = 1'b1;
   logic        icache_data_ready = 1'b0;
   logic [31:0] icache_data = 32'h0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_target = 32'h0;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready = 1'b0;

   int total = 0;
   int bad   = 0;
   int lat   = 1;
   int edge_k = 0;
   logic [31:0] q_addr [$];
   int          q_due  [$];

   riscv_fetch_queue #(.DEPTH(DEPTH), .RESET_VECTOR(32'h0000_0000)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .icache_addr_valid (icache_addr_valid),
      .icache_addr       (icache_addr),
      .icache_addr_ready (icache_addr_ready),
      .icache_data_ready (icache_data_ready),
      .icache_data       (icache_data),
      .redirect_valid    (redirect_valid),
      .redirect_target   (redirect_target),
      .instr_valid       (instr_valid),
      .instr             (instr),
      .instr_pc          (instr_pc),
      .instr_ready       (instr_ready)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] idata(input logic [31:0] a);
      return a ^ 32'h5A5A_0003;
   endfunction

   // icache: a request accepted in cycle n is answered in cycle n+lat, strictly in order.
   initial begin
      forever begin
         @(posedge clk);
         edge_k++;
         if (!rst_n) begin
            q_addr.delete();
            q_due.delete();
         end else begin
            if (icache_data_ready) begin
               void'(q_addr.pop_front());
               void'(q_due.pop_front());
            end
            if (icache_addr_valid && icache_addr_ready) begin
               q_addr.push_back(icache_addr);
               q_due.push_back(edge_k - 1 + lat);
            end
         end
         #1;
         if (rst_n && q_addr.size() > 0 && q_due[0] <= edge_k) begin
            icache_data_ready = 1'b1;
            icache_data       = idata(q_addr[0]);
         end else begin
            icache_data_ready = 1'b0;
            icache_data       = 32'h0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   task automatic do_reset(input int l);
      rst_n             = 1'b0;
      instr_ready       = 1'b1;
      icache_addr_ready = 1'b1;
      redirect_valid    = 1'b0;
      redirect_target   = 32'h0;
      lat               = l;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      instr_ready = 1'b1;
      lat = 1;
      repeat (2) @(negedge clk);
      #1;
      total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_instr_valid got=%b want=0", instr_valid); end
      total++; if (icache_addr_valid !== 1'b0) begin bad++; $display("FAIL reset_addr_valid got=%b want=0", icache_addr_valid); end
      total++; if (instr !== 32'h13) begin bad++; $display("FAIL reset_instr got=%h want=00000013", instr); end
      total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL reset_instr_pc got=%h want=00000000", instr_pc); end
      rst_n = 1'b1;
      #1;
      total++; if (icache_addr_valid !== 1'b1 || icache_addr !== 32'h0) begin
         bad++; $display("FAIL reset_first_req got valid=%b addr=%h want valid=1 addr=00000000", icache_addr_valid, icache_addr);
      end
   endtask

   task automatic test_stream();
      logic [31:0] exp;
      do_reset(1);
      @(negedge clk);
      total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL stream_cycle1_valid got=%b want=0", instr_valid); end
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         exp = 32'(i * 4);
         total++; if (instr_valid !== 1'b1 || instr_pc !== exp) begin
            bad++; $display("FAIL stream_pc[%0d] got valid=%b pc=%h want valid=1 pc=%h", i, instr_valid, instr_pc, exp);
         end
         total++; if (instr !== idata(exp)) begin
            bad++; $display("FAIL stream_instr[%0d] got=%h want=%h", i, instr, idata(exp));
         end
         if (icache_addr_valid) begin
            total++; if ((icache_addr - instr_pc) >= 32'(4 * DEPTH)) begin
               bad++; $display("FAIL stream_ahead[%0d] got addr=%h head=%h want distance<%0d", i, icache_addr, instr_pc, 4 * DEPTH);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int acc = 0;
      int got = 0;
      logic [31:0] exp = 32'h0;
      do_reset(1);
      instr_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (icache_addr_valid && icache_addr_ready) acc++;
         @(negedge clk);
      end
      total++; if (acc != DEPTH) begin bad++; $display("FAIL bp_accepted got=%0d want=%0d", acc, DEPTH); end
      total++; if (icache_addr_valid !== 1'b0) begin bad++; $display("FAIL bp_addr_valid got=%b want=0", icache_addr_valid); end
      instr_ready = 1'b1;
      for (int j = 0; j < 20; j++) begin
         if (j == 1) begin
            total++; if (icache_addr_valid !== 1'b1 || icache_addr !== 32'h10) begin
               bad++; $display("FAIL bp_resume got valid=%b addr=%h want valid=1 addr=00000010", icache_addr_valid, icache_addr);
            end
         end
         if (instr_valid) begin
            total++; if (instr_pc !== exp || instr !== idata(exp)) begin
               bad++; $display("FAIL bp_order got pc=%h instr=%h want pc=%h instr=%h", instr_pc, instr, exp, idata(exp));
            end
            exp += 32'd4;
            got++;
         end
         @(negedge clk);
      end
      total++; if (got != 20) begin bad++; $display("FAIL bp_throughput got=%0d want=20", got); end
   endtask

   task automatic test_redirect_stale();
      int got = 0;
      logic [31:0] exp = 32'h100;
      do_reset(3);
      repeat (3) @(negedge clk);
      total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL redir_pre_valid got=%b want=0", instr_valid); end
      redirect_valid  = 1'b1;
      redirect_target = 32'h100;
      #1;
      total++; if (icache_addr_valid !== 1'b1 || icache_addr !== 32'h100) begin
         bad++; $display("FAIL redir_addr got valid=%b addr=%h want valid=1 addr=00000100", icache_addr_valid, icache_addr);
      end
      @(negedge clk);
      redirect_valid = 1'b0;
      #1;
      for (int c = 0; c < 30 && got < 4; c++) begin
         if (instr_valid) begin
            total++; if (instr_pc !== exp || instr !== idata(exp)) begin
               bad++; $display("FAIL redir_deliver got pc=%h instr=%h want pc=%h instr=%h", instr_pc, instr, exp, idata(exp));
            end
            exp += 32'd4;
            got++;
         end
         @(negedge clk);
      end
      total++; if (got != 4) begin bad++; $display("FAIL redir_timeout got=%0d want=4", got); end
   endtask

   task automatic test_back_to_back();
      int got = 0;
      logic [31:0] exp = 32'h200;
      do_reset(2);
      repeat (2) @(negedge clk);
      redirect_valid  = 1'b1;
      redirect_target = 32'h180;
      @(negedge clk);
      redirect_target = 32'h200;
      #1;
      total++; if (icache_addr !== 32'h200 || instr_valid !== 1'b0) begin
         bad++; $display("FAIL b2b_addr got addr=%h valid=%b want addr=00000200 valid=0", icache_addr, instr_valid);
      end
      @(negedge clk);
      redirect_valid = 1'b0;
      #1;
      for (int c = 0; c < 30 && got < 3; c++) begin
         if (instr_valid) begin
            total++; if (instr_pc !== exp || instr !== idata(exp)) begin
               bad++; $display("FAIL b2b_deliver got pc=%h instr=%h want pc=%h instr=%h", instr_pc, instr, exp, idata(exp));
            end
            exp += 32'd4;
            got++;
         end
         @(negedge clk);
      end
      total++; if (got != 3) begin bad++; $display("FAIL b2b_timeout got=%0d want=3", got); end
   endtask

   task automatic test_wrap();
      int got = 0;
      logic [31:0] exp = 32'hFFFF_FFFC;
      do_reset(1);
      redirect_valid  = 1'b1;
      redirect_target = 32'hFFFF_FFFE;
      #1;
      total++; if (icache_addr_valid !== 1'b1 || icache_addr !== 32'hFFFF_FFFC) begin
         bad++; $display("FAIL wrap_addr got valid=%b addr=%h want valid=1 addr=fffffffc", icache_addr_valid, icache_addr);
      end
      @(negedge clk);
      redirect_valid = 1'b0;
      #1;
      total++; if (icache_addr !== 32'h0) begin bad++; $display("FAIL wrap_next_addr got=%h want=00000000", icache_addr); end
      for (int c = 0; c < 20 && got < 3; c++) begin
         if (instr_valid) begin
            total++; if (instr_pc !== exp || instr !== idata(exp)) begin
               bad++; $display("FAIL wrap_deliver got pc=%h instr=%h want pc=%h instr=%h", instr_pc, instr, exp, idata(exp));
            end
            exp += 32'd4;
            got++;
         end
         @(negedge clk);
      end
      total++; if (got != 3) begin bad++; $display("FAIL wrap_timeout got=%0d want=3", got); end
   endtask

   task automatic test_async_reset();
      int got = 0;
      logic [31:0] exp = 32'h0;
      do_reset(1);
      instr_ready = 1'b0;
      repeat (8) @(negedge clk);
      total++; if (instr_valid !== 1'b1 || icache_addr_valid !== 1'b0) begin
         bad++; $display("FAIL areset_full got valid=%b addr_valid=%b want valid=1 addr_valid=0", instr_valid, icache_addr_valid);
      end
      #2;
      rst_n = 1'b0;
      #1;
      total++; if (instr_valid !== 1'b0 || icache_addr_valid !== 1'b0) begin
         bad++; $display("FAIL areset_immediate got valid=%b addr_valid=%b want 0 0", instr_valid, icache_addr_valid);
      end
      total++; if (instr !== 32'h13 || instr_pc !== 32'h0) begin
         bad++; $display("FAIL areset_head got instr=%h pc=%h want 00000013 00000000", instr, instr_pc);
      end
      repeat (2) @(negedge clk);
      instr_ready = 1'b1;
      rst_n = 1'b1;
      #1;
      total++; if (icache_addr_valid !== 1'b1 || icache_addr !== 32'h0) begin
         bad++; $display("FAIL areset_first_req got valid=%b addr=%h want valid=1 addr=00000000", icache_addr_valid, icache_addr);
      end
      for (int c = 0; c < 20 && got < 3; c++) begin
         if (instr_valid) begin
            total++; if (instr_pc !== exp || instr !== idata(exp)) begin
               bad++; $display("FAIL areset_deliver got pc=%h instr=%h want pc=%h instr=%h", instr_pc, instr, exp, idata(exp));
            end
            exp += 32'd4;
            got++;
         end
         @(negedge clk);
      end
      total++; if (got != 3) begin bad++; $display("FAIL areset_timeout got=%0d want=3", got); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_stale();
      test_back_to_back();
      test_wrap();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
